// File: rtl/detector_sweep_ctrl.sv
// detector_sweep_ctrl: drives A/B/C of the 3-input "at most one high"
// detector through all 8 vectors, samples Q after settling and scores it
// against a golden model. Optional feature macro: DET_SWEEP_LOOP_EN
// (repeat the sweep forever instead of stopping in DONE).
module detector_sweep_ctrl #(
    parameter int unsigned DIV_W      = 24,
    parameter int unsigned DIV_MAX    = 12_499_999,
    parameter int unsigned SETTLE_CYC = 2           // legal range 1..15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       step_mode,
    input  logic       step,
    input  logic       q_in,
    output logic       a_out,
    output logic       b_out,
    output logic       c_out,
    output logic [2:0] vec_led,
    output logic       q_led,
    output logic       busy,
    output logic       done,
    output logic [3:0] q_cnt,
    output logic       err,
    output logic [3:0] err_cnt
);
    localparam int unsigned SET_W = 4;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned VEC_W = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_SAMPLE,
        S_HOLD,
        S_DONE
    } state_t;

    state_t             r_state,   w_state_nxt;
    logic [VEC_W-1:0]   r_vec,     w_vec_nxt;
    logic [DIV_W-1:0]   r_div,     w_div_nxt;
    logic [SET_W-1:0]   r_set,     w_set_nxt;
    logic [VEC_W-1:0]   r_abc,     w_abc_nxt;
    logic               r_q_led,   w_q_led_nxt;
    logic               r_busy,    w_busy_nxt;
    logic               r_done,    w_done_nxt;
    logic [CNT_W-1:0]   r_q_cnt,   w_q_cnt_nxt;
    logic               r_err,     w_err_nxt;
    logic [CNT_W-1:0]   r_err_cnt, w_err_cnt_nxt;
    logic               r_step_d;

    logic               w_step_rise;
    logic               w_expected;
    logic               w_hold_exit;

    // Next-state and next-output logic for the sweep sequencer.
    always_comb begin
        w_state_nxt   = r_state;
        w_vec_nxt     = r_vec;
        w_div_nxt     = r_div;
        w_set_nxt     = r_set;
        w_abc_nxt     = r_abc;
        w_q_led_nxt   = r_q_led;
        w_q_cnt_nxt   = r_q_cnt;
        w_err_nxt     = r_err;
        w_err_cnt_nxt = r_err_cnt;
        w_done_nxt    = 1'b0;

        w_step_rise = step & ~r_step_d;
        w_expected  = (r_vec == 3'b000) || (r_vec == 3'b001) ||
                      (r_vec == 3'b010) || (r_vec == 3'b100);
        // Mode is re-evaluated every HOLD cycle; prescaler saturates at DIV_MAX.
        w_hold_exit = step_mode ? w_step_rise : (r_div == DIV_W'(DIV_MAX));

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt   = S_DRIVE;
                    w_vec_nxt     = '0;
                    w_q_cnt_nxt   = '0;
                    w_err_nxt     = 1'b0;
                    w_err_cnt_nxt = '0;
                end
            end
            S_DRIVE: begin
                w_abc_nxt   = r_vec;
                w_set_nxt   = SET_W'(SETTLE_CYC - 1);
                w_state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                if (r_set == '0) begin
                    w_state_nxt = S_SAMPLE;
                end else begin
                    w_set_nxt = r_set - SET_W'(1);
                end
            end
            S_SAMPLE: begin
                w_q_led_nxt = q_in;
                if (q_in) begin
                    w_q_cnt_nxt = r_q_cnt + CNT_W'(1);
                end
                if (q_in != w_expected) begin
                    w_err_nxt     = 1'b1;
                    w_err_cnt_nxt = r_err_cnt + CNT_W'(1);
                end
                w_div_nxt   = '0;
                w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (r_div != DIV_W'(DIV_MAX)) begin
                    w_div_nxt = r_div + DIV_W'(1);
                end
                if (w_hold_exit) begin
                    if (r_vec == 3'd7) begin
`ifdef DET_SWEEP_LOOP_EN
                        w_vec_nxt     = '0;
                        w_q_cnt_nxt   = '0;
                        w_err_cnt_nxt = '0;
                        w_done_nxt    = 1'b1;
                        w_state_nxt   = S_DRIVE;
`else
                        w_state_nxt   = S_DONE;
`endif
                    end else begin
                        w_vec_nxt   = r_vec + VEC_W'(1);
                        w_state_nxt = S_DRIVE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt == S_DRIVE) || (w_state_nxt == S_SETTLE) ||
                     (w_state_nxt == S_SAMPLE) || (w_state_nxt == S_HOLD);
`ifndef DET_SWEEP_LOOP_EN
        w_done_nxt = (w_state_nxt == S_DONE);
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath, counters, registered outputs and step edge register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vec     <= '0;
            r_div     <= '0;
            r_set     <= '0;
            r_abc     <= '0;
            r_q_led   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_q_cnt   <= '0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
            r_step_d  <= 1'b0;
        end else begin
            r_vec     <= w_vec_nxt;
            r_div     <= w_div_nxt;
            r_set     <= w_set_nxt;
            r_abc     <= w_abc_nxt;
            r_q_led   <= w_q_led_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_q_cnt   <= w_q_cnt_nxt;
            r_err     <= w_err_nxt;
            r_err_cnt <= w_err_cnt_nxt;
            r_step_d  <= step;
        end
    end

    assign a_out   = r_abc[2];
    assign b_out   = r_abc[1];
    assign c_out   = r_abc[0];
    assign vec_led = r_abc;
    assign q_led   = r_q_led;
    assign busy    = r_busy;
    assign done    = r_done;
    assign q_cnt   = r_q_cnt;
    assign err     = r_err;
    assign err_cnt = r_err_cnt;

endmodule
